// File: rtl/linear_layer_start_fifo_srl.sv
// linear_layer_start_fifo_srl
//   Start-token FIFO between an upstream stage and a PE stage of the
//   Linear_Layer dataflow region. Tokens are stored in a write-enabled shift
//   register. The read address follows occupancy, so the oldest token is
//   always at SRL[cnt-1].
//   The head token is presented first-word fall-through on if_dout.
//   Optional sticky overflow/underflow flags: define LINEAR_LAYER_START_FIFO_ERR_EN.
module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
    ,
    output logic                  err_ovf,
    output logic                  err_udf
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   cnt_d;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic [DATA_WIDTH-1:0] srl_q [DEPTH];
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   addr_ext;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Accepted handshakes: qualified by the registered flags, so requests
    // against a full/empty FIFO never touch state.
    always_comb begin
        push = if_write & if_write_ce & full_n_q;
        pop  = if_read  & if_read_ce  & empty_n_q;
    end

    // Next-state occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    // Occupancy and registered status flags, derived from next-state count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            full_n_q  <= (cnt_d != DEPTH_C);
            empty_n_q <= (cnt_d != '0);
        end
    end

    // Token storage: shift on every accepted push. Contents are not reset;
    // the push is masked during reset so a reset-cycle write is fully ignored.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            srl_q[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                srl_q[i] <= srl_q[i-1];
            end
        end
    end

    // Read address points at the oldest entry; it grows with each shift so
    // the head token stays put across later pushes.
    always_comb begin
        addr_ext = (cnt_q != '0) ? (cnt_q - ONE_C) : '0;
        rd_addr  = addr_ext[ADDR_WIDTH-1:0];
    end

    // Combinational head-of-FIFO read mux.
    always_comb begin
        if_dout = srl_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                if_dout = srl_q[i];
            end
        end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;

`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
    logic err_ovf_q;
    logic err_udf_q;

    // Sticky flags for requests dropped against a full or empty FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (if_write & if_write_ce & ~full_n_q) begin
                err_ovf_q <= 1'b1;
            end
            if (if_read & if_read_ce & ~empty_n_q) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Directed self-checking bench for linear_layer_start_fifo_srl.
// Main instance: DEPTH=2, DATA_WIDTH=1. Second instance: DEPTH=1.
module tb_linear_layer_start_fifo_srl;

    logic clk = 1'b0;
    logic reset_n;
    logic if_write_ce, if_write, if_din, if_full_n;
    logic if_read_ce, if_read, if_dout, if_empty_n;
    logic d1_write, d1_din, d1_full_n, d1_read, d1_dout, d1_empty_n;
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
    logic err_ovf, err_udf, d1_err_ovf, d1_err_udf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    linear_layer_start_fifo_srl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n)
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
        , .err_ovf(err_ovf), .err_udf(err_udf)
`endif
    );

    linear_layer_start_fifo_srl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_write_ce(1'b1), .if_write(d1_write), .if_din(d1_din), .if_full_n(d1_full_n),
        .if_read_ce(1'b1), .if_read(d1_read), .if_dout(d1_dout), .if_empty_n(d1_empty_n)
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
        , .err_ovf(d1_err_ovf), .err_udf(d1_err_udf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic d);
        if_write = 1'b1;
        if_din   = d;
        tick();
        if_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL reset_full_n: got %b want 1", if_full_n); end
        n_checks++; if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL reset_empty_n: got %b want 0", if_empty_n); end
        n_checks++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
        n_checks++; if ({err_ovf, err_udf} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {err_ovf, err_udf}); end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        do_push(1'b1);
        n_checks++; if (if_empty_n !== 1'b1) begin n_fail++; $display("FAIL fill1_empty_n: got %b want 1", if_empty_n); end
        n_checks++; if (if_dout !== 1'b1) begin n_fail++; $display("FAIL fill1_dout: got %b want 1", if_dout); end
        n_checks++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL fill1_full_n: got %b want 1", if_full_n); end
        do_push(1'b0);
        n_checks++; if (if_full_n !== 1'b0) begin n_fail++; $display("FAIL fill2_full_n: got %b want 0", if_full_n); end
        n_checks++; if (if_dout !== 1'b1) begin n_fail++; $display("FAIL fill2_head_stable: got %b want 1", if_dout); end
        n_checks++; if (dut.cnt_q !== 2'd2) begin n_fail++; $display("FAIL fill2_cnt: got %0d want 2", dut.cnt_q); end
        if_read = 1'b1;
        tick();
        n_checks++; if (if_dout !== 1'b0) begin n_fail++; $display("FAIL pop1_dout: got %b want 0", if_dout); end
        n_checks++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL pop1_full_n: got %b want 1", if_full_n); end
        n_checks++; if (if_empty_n !== 1'b1) begin n_fail++; $display("FAIL pop1_empty_n: got %b want 1", if_empty_n); end
        tick();
        if_read = 1'b0;
        n_checks++; if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL pop2_empty_n: got %b want 0", if_empty_n); end
        n_checks++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL pop2_full_n: got %b want 1", if_full_n); end
        n_checks++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL pop2_cnt: got %0d want 0", dut.cnt_q); end
    endtask

    task automatic test_full_push_pop();
        do_push(1'b1);
        do_push(1'b0);
        // Full: the push is blocked, only the pop of token 1 happens.
        if_write = 1'b1;
        if_din   = 1'b1;
        if_read  = 1'b1;
        tick();
        if_write = 1'b0;
        if_read  = 1'b0;
        n_checks++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL fullpp_full_n: got %b want 1", if_full_n); end
        n_checks++; if (dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL fullpp_cnt: got %0d want 1", dut.cnt_q); end
        n_checks++; if (if_dout !== 1'b0) begin n_fail++; $display("FAIL fullpp_dout: got %b want 0", if_dout); end
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL fullpp_err_ovf: got %b want 1", err_ovf); end
`endif
    endtask

    task automatic test_one_push_pop();
        // One entry (token 0) held; pop it while pushing token 1.
        if_write = 1'b1;
        if_din   = 1'b1;
        if_read  = 1'b1;
        tick();
        if_write = 1'b0;
        if_read  = 1'b0;
        n_checks++; if (dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL onepp_cnt: got %0d want 1", dut.cnt_q); end
        n_checks++; if (if_dout !== 1'b1) begin n_fail++; $display("FAIL onepp_dout: got %b want 1", if_dout); end
        n_checks++; if ({if_full_n, if_empty_n} !== 2'b11) begin n_fail++; $display("FAIL onepp_flags: got %b want 11", {if_full_n, if_empty_n}); end
        // CE low masks a read request.
        if_read_ce = 1'b0;
        if_read    = 1'b1;
        tick();
        n_checks++; if (dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL ce_mask_cnt: got %0d want 1", dut.cnt_q); end
        if_read_ce = 1'b1;
        tick();
        if_read = 1'b0;
        n_checks++; if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL onepp_drain: got %b want 0", if_empty_n); end
    endtask

    task automatic test_underflow();
        if_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({if_full_n, if_empty_n} !== 2'b10) begin n_fail++; $display("FAIL udf_flags[%0d]: got %b want 10", i, {if_full_n, if_empty_n}); end
            n_checks++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL udf_cnt[%0d]: got %0d want 0", i, dut.cnt_q); end
        end
        if_read = 1'b0;
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
        tick();
        n_checks++; if (err_udf !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %b want 1", err_udf); end
`endif
    endtask

    task automatic test_reset_mid();
        do_push(1'b1);
        do_push(1'b1);
        n_checks++; if (if_full_n !== 1'b0) begin n_fail++; $display("FAIL rmid_full_before: got %b want 0", if_full_n); end
        reset_n  = 1'b0;
        if_write = 1'b1;
        if_din   = 1'b1;
        tick();
        reset_n  = 1'b1;
        if_write = 1'b0;
        n_checks++; if ({if_full_n, if_empty_n} !== 2'b10) begin n_fail++; $display("FAIL rmid_flags: got %b want 10", {if_full_n, if_empty_n}); end
        n_checks++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", dut.cnt_q); end
`ifdef LINEAR_LAYER_START_FIFO_ERR_EN
        n_checks++; if ({err_ovf, err_udf} !== 2'b00) begin n_fail++; $display("FAIL rmid_err: got %b want 00", {err_ovf, err_udf}); end
`endif
        do_push(1'b0);
        n_checks++; if (if_empty_n !== 1'b1) begin n_fail++; $display("FAIL rmid_push_empty_n: got %b want 1", if_empty_n); end
        n_checks++; if (if_dout !== 1'b0) begin n_fail++; $display("FAIL rmid_push_dout: got %b want 0", if_dout); end
        n_checks++; if (dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL rmid_push_cnt: got %0d want 1", dut.cnt_q); end
    endtask

    task automatic test_depth1();
        n_checks++; if ({d1_full_n, d1_empty_n} !== 2'b10) begin n_fail++; $display("FAIL d1_init: got %b want 10", {d1_full_n, d1_empty_n}); end
        d1_write = 1'b1;
        d1_din   = 1'b1;
        tick();
        n_checks++; if ({d1_full_n, d1_empty_n} !== 2'b01) begin n_fail++; $display("FAIL d1_push: got %b want 01", {d1_full_n, d1_empty_n}); end
        n_checks++; if (d1_dout !== 1'b1) begin n_fail++; $display("FAIL d1_dout: got %b want 1", d1_dout); end
        // Second push while full is dropped; head unchanged.
        d1_din = 1'b0;
        tick();
        d1_write = 1'b0;
        n_checks++; if (d1_dout !== 1'b1) begin n_fail++; $display("FAIL d1_blocked_dout: got %b want 1", d1_dout); end
        n_checks++; if ({d1_full_n, d1_empty_n} !== 2'b01) begin n_fail++; $display("FAIL d1_blocked_flags: got %b want 01", {d1_full_n, d1_empty_n}); end
        d1_read = 1'b1;
        tick();
        d1_read = 1'b0;
        n_checks++; if ({d1_full_n, d1_empty_n} !== 2'b10) begin n_fail++; $display("FAIL d1_pop: got %b want 10", {d1_full_n, d1_empty_n}); end
    endtask

    initial begin
        reset_n     = 1'b0;
        if_write_ce = 1'b1;
        if_read_ce  = 1'b1;
        if_write    = 1'b0;
        if_read     = 1'b0;
        if_din      = 1'b0;
        d1_write    = 1'b0;
        d1_din      = 1'b0;
        d1_read     = 1'b0;
        #1;
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_one_push_pop();
        test_underflow();
        test_reset_mid();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
